// File: rtl/dogm132_pkg.sv
// Shared constants, opcode values, widths and decoder state type for the DOGM132 receive model.
package dogm132_pkg;

    localparam int PAGES  = 4;
    localparam int PAGE_W = 2;
    localparam int COL_W  = 8;

    localparam logic [COL_W-1:0] COL_MAX = 8'd131;

    localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
    localparam logic [7:0] CMD_ADC_NORM = 8'hA0;
    localparam logic [7:0] CMD_ADC_REV  = 8'hA1;
    localparam logic [7:0] CMD_COM_NORM = 8'hC0;
    localparam logic [7:0] CMD_COM_REV  = 8'hC8;
    localparam logic [7:0] CMD_INV_OFF  = 8'hA6;
    localparam logic [7:0] CMD_INV_ON   = 8'hA7;
    localparam logic [7:0] CMD_IND_OFF  = 8'hAC;
    localparam logic [7:0] CMD_IND_ON   = 8'hAD;
    localparam logic [7:0] CMD_VOLUME   = 8'h81;
    localparam logic [7:0] CMD_BOOSTER  = 8'hF8;
    localparam logic [7:0] CMD_RESET    = 8'hE2;
    localparam logic [7:0] CMD_PAGE     = 8'hB0;

    localparam logic [5:0] VOLUME_RST = 6'h20;

    typedef enum logic [1:0] {
        ST_CMD,
        ST_ARG_VOL,
        ST_ARG_BOOST,
        ST_ARG_IND
    } dec_state_t;

    // Column set commands may assemble an address past the last column; pin it there.
    function automatic logic [COL_W-1:0] clamp_col(input logic [COL_W-1:0] c);
        return (c > COL_MAX) ? COL_MAX : c;
    endfunction

endpackage

// File: rtl/dogm132_spi_deser.sv
// SPI slave deserialiser: 2-FF input synchronisers, SCK rise detect, MSB-first shift register.
module dogm132_spi_deser
    import dogm132_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       clear,
    input  logic       cs_n,
    input  logic       sck,
    input  logic       sdata,
    input  logic       a0,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       rx_a0
);

    logic [1:0] cs_sync;
    logic [1:0] sck_sync;
    logic [1:0] data_sync;
    logic [1:0] a0_sync;
    logic       sck_prev;
    logic       sck_rise;
    logic [2:0] bit_cnt;
    logic [7:0] shift;

    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign rx_byte  = shift;

    // Synchronisers only see the hard reset: clearing them on a soft reset
    // while SCK is still high would fabricate a rising edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cs_sync   <= 2'b11;
            sck_sync  <= 2'b00;
            data_sync <= 2'b00;
            a0_sync   <= 2'b00;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], cs_n};
            sck_sync  <= {sck_sync[0], sck};
            data_sync <= {data_sync[0], sdata};
            a0_sync   <= {a0_sync[0], a0};
            sck_prev  <= sck_sync[1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in || clear) begin
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            byte_done <= 1'b0;
            rx_a0     <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_sync[1]) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                shift   <= {shift[6:0], data_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    rx_a0     <= a0_sync[1];
                end
            end
        end
    end

endmodule

// File: rtl/dogm132_ctrl_model.sv
// DOGM132 receive model: command decoder, page/column addressing, 4x132 display RAM, readback.
// Optional received-byte log ports are built when DOGM132_BYTE_LOG_EN is defined.
module dogm132_ctrl_model
    import dogm132_pkg::*;
(
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              disp_cs_n_i,
    input  logic              disp_sck_i,
    input  logic              disp_data_i,
    input  logic              disp_addr_i,
    input  logic [PAGE_W-1:0] rd_page_i,
    input  logic [COL_W-1:0]  rd_col_i,
    output logic [7:0]        rd_data_o,
    output logic              disp_on_o,
    output logic              adc_rev_o,
    output logic              com_rev_o,
    output logic              inverse_o,
    output logic [4:0]        start_line_o,
    output logic [5:0]        volume_o
`ifdef DOGM132_BYTE_LOG_EN
    ,
    output logic              byte_valid_o,
    output logic [7:0]        byte_o,
    output logic              byte_a0_o
`endif
);

    logic              byte_done;
    logic [7:0]        rx_byte;
    logic              rx_a0;
    logic              soft_rst;
    logic              data_wr;
    dec_state_t        state;
    logic [PAGE_W-1:0] page;
    logic [COL_W-1:0]  col;

    logic [7:0] ram [0:PAGES-1][0:int'(COL_MAX)];

    dogm132_spi_deser u_deser (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .clear     (soft_rst),
        .cs_n      (disp_cs_n_i),
        .sck       (disp_sck_i),
        .sdata     (disp_data_i),
        .a0        (disp_addr_i),
        .byte_done (byte_done),
        .rx_byte   (rx_byte),
        .rx_a0     (rx_a0)
    );

    // Soft reset is a command, so it only counts outside argument states.
    assign soft_rst = byte_done && !rx_a0 && (state == ST_CMD) && (rx_byte == CMD_RESET);
    assign data_wr  = byte_done && rx_a0 && !reset_in;

    always_ff @(posedge clk_in) begin
        if (reset_in || soft_rst) begin
            state        <= ST_CMD;
            page         <= '0;
            col          <= '0;
            disp_on_o    <= 1'b0;
            adc_rev_o    <= 1'b0;
            com_rev_o    <= 1'b0;
            inverse_o    <= 1'b0;
            start_line_o <= 5'd0;
            volume_o     <= VOLUME_RST;
        end else if (byte_done) begin
            if (rx_a0) begin
                if (col < COL_MAX)
                    col <= col + 8'd1;
                state <= ST_CMD;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (rx_byte[7:4] == 4'h0)
                            col <= clamp_col({col[7:4], rx_byte[3:0]});
                        else if (rx_byte[7:4] == 4'h1)
                            col <= clamp_col({rx_byte[3:0], col[3:0]});
                        else if (rx_byte[7:2] == CMD_PAGE[7:2])
                            page <= rx_byte[PAGE_W-1:0];
                        else if (rx_byte[7:6] == 2'b01)
                            start_line_o <= rx_byte[4:0];
                        else begin
                            case (rx_byte)
                                CMD_DISP_OFF:           disp_on_o <= 1'b0;
                                CMD_DISP_ON:            disp_on_o <= 1'b1;
                                CMD_ADC_NORM:           adc_rev_o <= 1'b0;
                                CMD_ADC_REV:            adc_rev_o <= 1'b1;
                                CMD_COM_NORM:           com_rev_o <= 1'b0;
                                CMD_COM_REV:            com_rev_o <= 1'b1;
                                CMD_INV_OFF:            inverse_o <= 1'b0;
                                CMD_INV_ON:             inverse_o <= 1'b1;
                                CMD_VOLUME:             state     <= ST_ARG_VOL;
                                CMD_BOOSTER:            state     <= ST_ARG_BOOST;
                                CMD_IND_OFF, CMD_IND_ON: state    <= ST_ARG_IND;
                                default: ;
                            endcase
                        end
                    end
                    ST_ARG_VOL: begin
                        volume_o <= rx_byte[5:0];
                        state    <= ST_CMD;
                    end
                    default: state <= ST_CMD;
                endcase
            end
        end
    end

    // NOTE: the display RAM has no reset; neither reset_in nor a soft reset may clear pixel contents.
    always_ff @(posedge clk_in) begin
        if (data_wr)
            ram[page][col] <= rx_byte;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in || soft_rst)
            rd_data_o <= 8'h00;
        else if (rd_col_i <= COL_MAX)
            rd_data_o <= ram[rd_page_i][rd_col_i];
        else
            rd_data_o <= 8'h00;
    end

`ifdef DOGM132_BYTE_LOG_EN
    assign byte_valid_o = byte_done;
    assign byte_o       = rx_byte;
    assign byte_a0_o    = rx_a0;
`endif

endmodule

// File: tb/tb_dogm132_ctrl_model.sv
// Self-checking bench for dogm132_ctrl_model: SPI byte driver, readback scoreboard, mode checks.
module tb_dogm132_ctrl_model;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       disp_cs_n_i, disp_sck_i, disp_data_i, disp_addr_i;
    logic [1:0] rd_page_i;
    logic [7:0] rd_col_i;
    logic [7:0] rd_data_o;
    logic       disp_on_o, adc_rev_o, com_rev_o, inverse_o;
    logic [4:0] start_line_o;
    logic [5:0] volume_o;
`ifdef DOGM132_BYTE_LOG_EN
    logic       byte_valid_o;
    logic [7:0] byte_o;
    logic       byte_a0_o;
    logic [8:0] log_q [$];
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] rb_q [$];
    logic [7:0] init_seq [0:13];

    always #5 clk_in = ~clk_in;

    dogm132_ctrl_model dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .disp_cs_n_i  (disp_cs_n_i),
        .disp_sck_i   (disp_sck_i),
        .disp_data_i  (disp_data_i),
        .disp_addr_i  (disp_addr_i),
        .rd_page_i    (rd_page_i),
        .rd_col_i     (rd_col_i),
        .rd_data_o    (rd_data_o),
        .disp_on_o    (disp_on_o),
        .adc_rev_o    (adc_rev_o),
        .com_rev_o    (com_rev_o),
        .inverse_o    (inverse_o),
        .start_line_o (start_line_o),
        .volume_o     (volume_o)
`ifdef DOGM132_BYTE_LOG_EN
        ,
        .byte_valid_o (byte_valid_o),
        .byte_o       (byte_o),
        .byte_a0_o    (byte_a0_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shifts out nbits of b MSB first; only complete bytes are expected in the log.
    task automatic send_byte(input logic [7:0] b, input logic a0, input int nbits);
`ifdef DOGM132_BYTE_LOG_EN
        if (nbits == 8)
            log_q.push_back({a0, b});
`endif
        @(negedge clk_in);
        disp_addr_i = a0;
        disp_cs_n_i = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            disp_data_i = b[7-i];
            repeat (4) @(negedge clk_in);
            disp_sck_i = 1'b1;
            repeat (4) @(negedge clk_in);
            disp_sck_i = 1'b0;
        end
        repeat (6) @(negedge clk_in);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(b, 1'b0, 8);
    endtask

    task automatic dat(input logic [7:0] b);
        send_byte(b, 1'b1, 8);
    endtask

    task automatic cs_release();
        disp_cs_n_i = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] p, input logic [7:0] c,
                            input logic [7:0] exp);
        @(negedge clk_in);
        rd_page_i = p;
        rd_col_i  = c;
        rb_q.push_back(exp);
        @(negedge clk_in);
        check(tag, rd_data_o, rb_q.pop_front());
    endtask

    task automatic check_reset_regs(input string tag);
        check({tag, "_disp_on"}, disp_on_o, 1'b0);
        check({tag, "_adc"},     adc_rev_o, 1'b0);
        check({tag, "_com"},     com_rev_o, 1'b0);
        check({tag, "_inv"},     inverse_o, 1'b0);
        check({tag, "_start"},   start_line_o, 5'd0);
        check({tag, "_volume"},  volume_o, 6'h20);
    endtask

`ifdef DOGM132_BYTE_LOG_EN
    always @(negedge clk_in) begin
        if (byte_valid_o) begin
            if (log_q.size() == 0)
                check("log_unexpected", {byte_a0_o, byte_o}, 9'h000);
            else
                check("log_byte", {byte_a0_o, byte_o}, log_q.pop_front());
        end
    end
`endif

    initial begin
        init_seq = '{8'h40, 8'hA1, 8'hC0, 8'hA6, 8'hA2, 8'h2F, 8'hF8,
                     8'h00, 8'h23, 8'h81, 8'h1F, 8'hAC, 8'h00, 8'hAF};
        reset_in    = 1'b1;
        disp_cs_n_i = 1'b1;
        disp_sck_i  = 1'b0;
        disp_data_i = 1'b0;
        disp_addr_i = 1'b0;
        rd_page_i   = 2'd0;
        rd_col_i    = 8'd0;
        repeat (5) @(negedge clk_in);
        check_reset_regs("por");
        check("por_rd_data", rd_data_o, 8'h00);
        reset_in = 1'b0;

        // Init stream with argument bytes for booster, volume and indicator.
        foreach (init_seq[i]) cmd(init_seq[i]);
        cs_release();
        check("init_adc",     adc_rev_o, 1'b1);
        check("init_com",     com_rev_o, 1'b0);
        check("init_volume",  volume_o, 6'h1F);
        check("init_disp_on", disp_on_o, 1'b1);
        check("init_start",   start_line_o, 5'd0);
        check("init_inv",     inverse_o, 1'b0);

        cmd(8'hB2); cmd(8'h10); cmd(8'h05);
        dat(8'h55); dat(8'hAA);
        cs_release();
        rd_check("ram_2_5", 2'd2, 8'd5, 8'h55);
        rd_check("ram_2_6", 2'd2, 8'd6, 8'hAA);

        // Column 130 then three writes: last two land on column 131.
        cmd(8'h18); cmd(8'h02);
        dat(8'h01); dat(8'h02); dat(8'h03);
        rd_check("ram_2_130", 2'd2, 8'd130, 8'h01);
        rd_check("ram_2_131", 2'd2, 8'd131, 8'h03);
        dat(8'h04);
        rd_check("col_hold_131", 2'd2, 8'd131, 8'h04);
        rd_check("col_hold_130", 2'd2, 8'd130, 8'h01);
        rd_check("rd_col_oob", 2'd2, 8'd200, 8'h00);

        // Partial byte aborted by CS; the next full byte must decode cleanly.
        cmd(8'h10); cmd(8'h00);
        send_byte(8'hFF, 1'b1, 5);
        cs_release();
        cmd(8'hB1);
        dat(8'h77);
        cs_release();
        rd_check("page1_col0", 2'd1, 8'd0, 8'h77);
        rd_check("partial_no_wr", 2'd2, 8'd131, 8'h04);

        // Data byte while waiting for the volume argument drops the argument.
        cmd(8'h81);
        dat(8'h3C);
        check("vol_after_data", volume_o, 6'h1F);
        rd_check("arg_drop_wr", 2'd1, 8'd1, 8'h3C);
        cmd(8'h05);
        check("vol_still", volume_o, 6'h1F);
        dat(8'h66);
        rd_check("fsm_in_cmd", 2'd1, 8'd5, 8'h66);

        cmd(8'h5F); cmd(8'hA7); cmd(8'hC8); cmd(8'hB4);
        dat(8'h99);
        check("start_max", start_line_o, 5'h1F);
        check("inv_on",    inverse_o, 1'b1);
        check("com_rev",   com_rev_o, 1'b1);
        rd_check("page_b4_ignored", 2'd1, 8'd6, 8'h99);
        cmd(8'h1F); cmd(8'h0F);
        dat(8'h11);
        cs_release();
        rd_check("col_clamp", 2'd1, 8'd131, 8'h11);

        // Soft reset: registers back to defaults, RAM retained, address back to 0/0.
        cmd(8'hE2);
        cs_release();
        check_reset_regs("soft");
        rd_check("soft_keep_1_0", 2'd1, 8'd0, 8'h77);
        dat(8'h5A);
        cs_release();
        rd_check("soft_addr_0_0", 2'd0, 8'd0, 8'h5A);

        // Hard reset in the middle of a data byte.
        cmd(8'hA7);
        send_byte(8'hFF, 1'b1, 5);
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        cs_release();
        check_reset_regs("hard");
        rd_check("hard_no_wr", 2'd0, 8'd0, 8'h5A);
        dat(8'hC3);
        cs_release();
        rd_check("hard_realign", 2'd0, 8'd0, 8'hC3);

`ifdef DOGM132_BYTE_LOG_EN
        check("log_drained", log_q.size(), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
